acq_stream_packer: RTL and testbench
====================================

// Module: acq_stream_packer
// PURPOSE
//  Parametrised successor to the acquisition-card ADC capture path.
//  - Accepts CH_NUM ADC sample streams and applies per-channel decimation.
//  - Packs the kept samples, tagged with their channel id, onto ONE valid/ready stream to the PC-side FIFO.
//  - Adds continuous and fixed-length burst capture modes, per-channel enable, and sticky overflow flags.
// PARAMETERS
//  CH_NUM    4   number of ADC input channels (1..16)
//  DW        16  sample width
//  DEC_W     16  decimation ratio register width
//  BURST_W   16  burst length register width
//  CW        $clog2(CH_NUM) channel-id width (localparam, minimum 1)
// PORTS
//  clk           in   1              system clock
//  rst           in   1              asynchronous reset, active-high
//  sysEn         in   1              global enable; low = flush and idle
//  mode          in   acqStreamMode_t  ACQ_CONT / ACQ_BURST; sampled only in IDLE on start
//  start         in   1              pulse: begin capture
//  stop          in   1              pulse: end continuous capture
//  chEn          in   CH_NUM         per-channel enable; sampled on start
//  decRatio      in   DEC_W          keep 1 of decRatio samples; 0 is treated as 1
//  burstLen      in   BURST_W        kept samples per channel in burst mode
//  ad_din        in   CH_NUM*DW      ADC samples
//  ad_dinValid   in   CH_NUM         ADC sample valid
//  ad_dinReady   out  CH_NUM         ADC sample ready
//  pk_dout       out  DW             packed sample
//  pk_doutChan   out  CW             channel id of pk_dout
//  pk_doutLast   out  1              final word of a burst
//  pk_doutValid  out  1              output valid
//  pk_doutReady  in   1              output ready
//  busy          out  1              FSM not IDLE
//  overflow      out  CH_NUM         sticky: kept sample dropped
//  ovfClr        in   1              clears overflow
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, hold regs empty, all counters 0.
//  FSM states:
//   - IDLE -> RUN on start & sysEn & |chEn; in ACQ_BURST also requires burstLen!=0, else start is ignored.
//   - RUN  -> DRAIN on stop (ACQ_CONT), or when every enabled channel's burst count reaches burstLen (ACQ_BURST).
//   - DRAIN -> IDLE when all hold regs are empty and the final word has been accepted.
//   - Any state -> IDLE on the cycle after sysEn=0.
//  ad_dinReady[i] = sysEn & RUN & chEnLatched[i]. ADC is never back-pressured beyond this.
//  Decimation: per-channel counter 0..max(decRatio,1)-1, advanced on each handshake. A sample is kept when the counter is 0. Counters clear on start.
//  Hold reg (1 deep per channel):
//   - A kept sample is written at the next edge.
//   - If the hold reg is still full and not being granted that cycle: new sample dropped, overflow[i] set. Drops do not count toward burstLen.
//   - Grant and refill in the same cycle is legal, with no drop.
//  Arbiter: round-robin over full hold regs, starting at last grant + 1. Grants only when the output reg is empty or being accepted that cycle.
//  Latency: ADC handshake at cycle t -> hold reg t+1 -> pk_doutValid t+2 (no contention). Throughput 1 word/cycle.
//  Output: standard valid/ready. While valid & !ready, data, chan and last are held stable.
//  pk_doutLast=1 only in burst mode, on the last word emitted in DRAIN (all hold regs empty after it). Never set in ACQ_CONT.
//  sysEn falling: hold regs flushed, counters cleared. A word already in the output reg stays valid until accepted.
//  Overflow: ovfClr and a new overflow in the same cycle -> the flag stays set.
//  Control changes: decRatio/chEn/mode changes during RUN are ignored (latched on start). Exception: decRatio is live-sampled at each counter wrap.
//  Counter widths: burst counters saturate at burstLen. Decimation counters are DEC_W wide and wrap to 0.
// STRUCTURE
//  Shared AcqCard package holds:
//   - typedef enum logic {ACQ_CONT, ACQ_BURST} acqStreamMode_t
//   - the FSM state enum acqPkState_t
//   - ACQ_PK_CH_MAX=16
//  Sub-module acq_rr_arbiter #(N): req[N], advance, grant onehot + index. Rotating priority pointer, async reset to index 0.
//  Top level holds the FSM, decimators, hold regs, burst counters and output reg.
// TESTING
//  1. CH_NUM=4, decRatio=1, CONT, all channels valid every cycle, ready=1
//     -> output chan order 0,1,2,3 repeating; overflow bits set (4 in, 1 out).
//  2. decRatio=4, CH0 only, samples 0..15
//     -> output 0,4,8,12 on chan 0; first word 2 cycles after the handshake of sample 0.
//  3. BURST, burstLen=3, chEn=4'b0101, decRatio=2
//     -> exactly 6 words (3 per ch0/ch2); pk_doutLast only on the 6th; busy falls after it is accepted.
//  4. pk_doutReady held 0 for 10 cycles with a pending word
//     -> pk_dout/pk_doutChan stable; ch overflow set; ovfClr clears it.
//  5. sysEn dropped mid-RUN with 2 hold regs full
//     -> next cycle IDLE, ad_dinReady=0; output word completes, no further words.
//  6. rst asserted asynchronously mid-burst
//     -> all outputs 0 immediately; burst restarts cleanly on the next start.

Source files
------------

// File: rtl/acq_stream_packer_pkg.sv
// Shared AcqCard types and constants for the acquisition stream packer.
// Imported by the packer top level and its round-robin arbiter.
package acq_stream_packer_pkg;

  localparam int ACQ_PK_CH_MAX = 16;

  typedef enum logic {ACQ_CONT, ACQ_BURST} acqStreamMode_t;

  typedef enum logic [1:0] {PK_IDLE, PK_RUN, PK_DRAIN} acqPkState_t;

  // Width of a channel index, never less than one bit.
  function automatic int unsigned chanWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acq_rr_arbiter.sv
// Round-robin arbiter: highest priority goes to the requester after the last grant.
// The priority pointer only moves when the caller consumes the grant.
module acq_rr_arbiter
  import acq_stream_packer_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = chanWidth(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic [IW-1:0] ptr;
  logic          found;
  int            cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (int'(index) == N - 1) ? '0 : index + IW'(1);
    end
  end

endmodule

// File: rtl/acq_stream_packer.sv
// Multi-channel ADC capture path: per-channel decimation and one-deep hold registers,
// round-robin packed onto a single valid/ready stream with continuous and burst modes.
module acq_stream_packer
  import acq_stream_packer_pkg::*;
#(
  parameter int CH_NUM  = 4,
  parameter int DW      = 16,
  parameter int DEC_W   = 16,
  parameter int BURST_W = 16,
  localparam int CW     = chanWidth(CH_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sysEn,
  input  acqStreamMode_t       mode,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CH_NUM-1:0]    chEn,
  input  logic [DEC_W-1:0]     decRatio,
  input  logic [BURST_W-1:0]   burstLen,
  input  logic [CH_NUM*DW-1:0] ad_din,
  input  logic [CH_NUM-1:0]    ad_dinValid,
  output logic [CH_NUM-1:0]    ad_dinReady,
  output logic [DW-1:0]        pk_dout,
  output logic [CW-1:0]        pk_doutChan,
  output logic                 pk_doutLast,
  output logic                 pk_doutValid,
  input  logic                 pk_doutReady,
  output logic                 busy,
  output logic [CH_NUM-1:0]    overflow,
  input  logic                 ovfClr
);

  acqPkState_t    state;
  acqStreamMode_t modeLat;
  logic [CH_NUM-1:0]  chEnLat;
  logic [BURST_W-1:0] burstLenLat;

  logic [DEC_W-1:0]   decCnt   [CH_NUM];
  logic [DEC_W-1:0]   decLat   [CH_NUM];
  logic [BURST_W-1:0] burstCnt [CH_NUM];
  logic [CH_NUM-1:0]  holdFull;
  logic [DW-1:0]      holdData [CH_NUM];

  logic [CH_NUM-1:0] hs, keep, drop, load, decWrap, chDone;
  logic [CH_NUM-1:0] grant, grantEff;
  logic [CW-1:0]     grantIdx;
  logic running, burstMode, burstDone, startOk, drainDone, advance, lastCond;

  assign running     = sysEn && (state == PK_RUN);
  assign ad_dinReady = {CH_NUM{running}} & chEnLat;
  assign hs          = ad_dinValid & ad_dinReady;
  assign busy        = (state != PK_IDLE);
  assign burstMode   = (modeLat == ACQ_BURST);

  assign startOk = (state == PK_IDLE) && start && sysEn && (|chEn) &&
                   ((mode == ACQ_CONT) || (burstLen != '0));

  // A ratio of 0 or 1 puts the wrap point at 0, so every sample is kept.
  always_comb begin
    decWrap = '0;
    chDone  = '0;
    keep    = '0;
    drop    = '0;
    load    = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      decWrap[i] = (decLat[i] <= DEC_W'(1)) || (decCnt[i] >= decLat[i] - DEC_W'(1));
      chDone[i]  = !chEnLat[i] || (burstCnt[i] >= burstLenLat);
      keep[i]    = hs[i] && (decCnt[i] == '0) &&
                   !(burstMode && (burstCnt[i] >= burstLenLat));
      drop[i]    = keep[i] && holdFull[i] && !grantEff[i];
      load[i]    = keep[i] && !drop[i];
    end
  end

  assign burstDone = burstMode && (&chDone);
  assign drainDone = (holdFull == '0) && (!pk_doutValid || pk_doutReady);
  assign advance   = sysEn && (!pk_doutValid || pk_doutReady) && (|holdFull);
  assign grantEff  = grant & {CH_NUM{advance}};

  // The final burst word is the one that leaves every hold register empty once no
  // further samples can be kept, which already holds in the last RUN cycle.
  assign lastCond = burstMode &&
                    ((state == PK_DRAIN) || ((state == PK_RUN) && burstDone)) &&
                    ((holdFull & ~grantEff) == '0);

  acq_rr_arbiter #(.N(CH_NUM)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (holdFull),
    .advance (advance),
    .grant   (grant),
    .index   (grantIdx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PK_IDLE;
      modeLat     <= ACQ_CONT;
      chEnLat     <= '0;
      burstLenLat <= '0;
    end else if (!sysEn) begin
      state <= PK_IDLE;
    end else begin
      case (state)
        PK_IDLE: begin
          if (startOk) begin
            state       <= PK_RUN;
            modeLat     <= mode;
            chEnLat     <= chEn;
            burstLenLat <= burstLen;
          end
        end
        PK_RUN: begin
          if ((!burstMode && stop) || burstDone) state <= PK_DRAIN;
        end
        PK_DRAIN: begin
          if (drainDone) state <= PK_IDLE;
        end
        default: state <= PK_IDLE;
      endcase
    end
  end

  // Decimation counters re-sample decRatio each time they wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdFull <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        decCnt[i]   <= '0;
        decLat[i]   <= '0;
        burstCnt[i] <= '0;
        holdData[i] <= '0;
      end
    end else if (!sysEn) begin
      holdFull <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        decCnt[i]   <= '0;
        burstCnt[i] <= '0;
      end
    end else if (startOk) begin
      for (int i = 0; i < CH_NUM; i++) begin
        decCnt[i]   <= '0;
        decLat[i]   <= decRatio;
        burstCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (hs[i]) begin
          if (decWrap[i]) begin
            decCnt[i] <= '0;
            decLat[i] <= decRatio;
          end else begin
            decCnt[i] <= decCnt[i] + DEC_W'(1);
          end
        end
        if (load[i]) begin
          holdFull[i] <= 1'b1;
          holdData[i] <= ad_din[i*DW +: DW];
          if (burstCnt[i] < burstLenLat) burstCnt[i] <= burstCnt[i] + BURST_W'(1);
        end else if (grantEff[i]) begin
          holdFull[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk_doutValid <= 1'b0;
      pk_dout      <= '0;
      pk_doutChan  <= '0;
      pk_doutLast  <= 1'b0;
    end else if (advance) begin
      pk_doutValid <= 1'b1;
      pk_dout      <= holdData[grantIdx];
      pk_doutChan  <= grantIdx;
      pk_doutLast  <= lastCond;
    end else if (pk_doutReady) begin
      pk_doutValid <= 1'b0;
      pk_doutLast  <= 1'b0;
    end
  end

  // A clear in the same cycle as a fresh drop leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= '0;
    end else begin
      overflow <= drop | (overflow & ~{CH_NUM{ovfClr}});
    end
  end

  assert property (@(posedge clk) disable iff (rst) $onehot0(grantEff));

  assert property (@(posedge clk) disable iff (rst)
    (pk_doutValid && !pk_doutReady) |=>
      (pk_doutValid && $stable(pk_dout) && $stable(pk_doutChan) && $stable(pk_doutLast)));

endmodule

// File: tb/tb_acq_stream_packer.sv
// Directed bench for acq_stream_packer: expected word queues built from the capture rules,
// one negedge compare process checking every accepted word and every stalled cycle.
module tb_acq_stream_packer;
  import acq_stream_packer_pkg::*;

  localparam int CH_NUM  = 4;
  localparam int DW      = 16;
  localparam int DEC_W   = 16;
  localparam int BURST_W = 16;
  localparam int CW      = chanWidth(CH_NUM);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sysEn;
  acqStreamMode_t       mode;
  logic                 start, stop, ovfClr;
  logic [CH_NUM-1:0]    chEn;
  logic [DEC_W-1:0]     decRatio;
  logic [BURST_W-1:0]   burstLen;
  logic [CH_NUM*DW-1:0] ad_din;
  logic [CH_NUM-1:0]    ad_dinValid, ad_dinReady;
  logic [DW-1:0]        pk_dout;
  logic [CW-1:0]        pk_doutChan;
  logic                 pk_doutLast, pk_doutValid, pk_doutReady;
  logic                 busy;
  logic [CH_NUM-1:0]    overflow;

  always #5 clk = ~clk;

  acq_stream_packer #(.CH_NUM(CH_NUM), .DW(DW), .DEC_W(DEC_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst(rst), .sysEn(sysEn), .mode(mode), .start(start), .stop(stop),
    .chEn(chEn), .decRatio(decRatio), .burstLen(burstLen),
    .ad_din(ad_din), .ad_dinValid(ad_dinValid), .ad_dinReady(ad_dinReady),
    .pk_dout(pk_dout), .pk_doutChan(pk_doutChan), .pk_doutLast(pk_doutLast),
    .pk_doutValid(pk_doutValid), .pk_doutReady(pk_doutReady),
    .busy(busy), .overflow(overflow), .ovfClr(ovfClr)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] chan;
    logic          last;
  } word_t;

  word_t expQ[$];
  word_t w;
  int testsRun = 0, testsFailed = 0;
  int cyc = 0;
  bit rrMode = 0;
  int rrIdx = 0, acceptCount = 0;
  int firstHsCyc = -1, firstOutCyc = -1, lastAccCyc = -1, busyFallCyc = -1;
  logic prevStall = 1'b0, prevBusy = 1'b0;
  logic [DW-1:0] savedData;
  logic [CW-1:0] savedChan;
  logic savedLast;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Compare process: every accepted word against the model, every stalled cycle for stability.
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_valid", {31'd0, pk_doutValid}, 32'd1);
        checkOutput("stall_data", {16'd0, pk_dout}, {16'd0, savedData});
        checkOutput("stall_chan", {30'd0, pk_doutChan}, {30'd0, savedChan});
        checkOutput("stall_last", {31'd0, pk_doutLast}, {31'd0, savedLast});
      end
      if (|(ad_dinValid & ad_dinReady) && firstHsCyc < 0) firstHsCyc = cyc;
      if (pk_doutValid && firstOutCyc < 0) firstOutCyc = cyc;
      if (pk_doutValid && pk_doutReady) begin
        acceptCount++;
        if (pk_doutLast) lastAccCyc = cyc;
        if (rrMode) begin
          checkOutput("rr_chan", {30'd0, pk_doutChan}, rrIdx % CH_NUM);
          checkOutput("rr_tag", {28'd0, pk_dout[15:12]}, rrIdx % CH_NUM);
          rrIdx++;
        end else if (expQ.size() == 0) begin
          checkOutput("unexpected_word", {31'd0, pk_doutValid}, 32'd0);
        end else begin
          w = expQ.pop_front();
          checkOutput("word_data", {16'd0, pk_dout}, {16'd0, w.data});
          checkOutput("word_chan", {30'd0, pk_doutChan}, {30'd0, w.chan});
          checkOutput("word_last", {31'd0, pk_doutLast}, {31'd0, w.last});
        end
      end
      prevStall = pk_doutValid && !pk_doutReady;
      savedData = pk_dout;
      savedChan = pk_doutChan;
      savedLast = pk_doutLast;
    end
    if (prevBusy && !busy) busyFallCyc = cyc;
    prevBusy = busy;
  end

  task automatic applyStimulus(input logic [CH_NUM-1:0] v, input logic [CH_NUM*DW-1:0] d);
    ad_dinValid = v;
    ad_din      = d;
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    ad_dinValid = '0; start = 0; stop = 0; ovfClr = 0; sysEn = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    expQ.delete();
    rrMode = 0; rrIdx = 0; acceptCount = 0;
    @(posedge clk); #1;
  endtask

  task automatic startCapture(input acqStreamMode_t m, input logic [CH_NUM-1:0] en,
                              input int dec, input int blen);
    mode = m; chEn = en; decRatio = DEC_W'(dec); burstLen = BURST_W'(blen);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stopCapture();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic waitIdle(input int maxCyc, input string name);
    int n = 0;
    while (busy && n < maxCyc) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({name, "_idle"}, {31'd0, busy}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  function automatic logic [CH_NUM*DW-1:0] allCh(input int base, input int n);
    logic [CH_NUM*DW-1:0] d = '0;
    for (int ch = 0; ch < CH_NUM; ch++) d[ch*DW +: DW] = DW'(ch * base + n);
    return d;
  endfunction

  initial begin
    rst = 1'b1; sysEn = 1; mode = ACQ_CONT; start = 0; stop = 0; ovfClr = 0;
    chEn = '0; decRatio = '0; burstLen = '0; ad_din = '0; ad_dinValid = '0; pk_doutReady = 1;

    // Reset state
    @(posedge clk); #1;
    checkOutput("rst_valid", {31'd0, pk_doutValid}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_ready", {28'd0, ad_dinReady}, 0);
    checkOutput("rst_ovf", {28'd0, overflow}, 0);
    checkOutput("rst_dout", {16'd0, pk_dout}, 0);
    checkOutput("rst_last", {31'd0, pk_doutLast}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: all channels every cycle, ratio 1 -> round-robin order, everyone overflows
    doReset();
    pk_doutReady = 1;
    startCapture(ACQ_CONT, 4'hF, 1, 0);
    checkOutput("t1_ready", {28'd0, ad_dinReady}, 32'hF);
    rrMode = 1;
    for (int n = 0; n < 20; n++) applyStimulus(4'hF, allCh(4096, n));
    applyStimulus('0, '0);
    stopCapture();
    waitIdle(50, "t1");
    checkOutput("t1_ovf", {28'd0, overflow}, 32'hF);
    checkOutput("t1_words", rrIdx, 23);
    rrMode = 0;

    // 2: ratio 4 on channel 0 only -> samples 0,4,8,12, two-cycle latency
    doReset();
    startCapture(ACQ_CONT, 4'b0001, 4, 0);
    for (int n = 0; n < 16; n++)
      if (n % 4 == 0) expQ.push_back('{data: DW'(n), chan: '0, last: 1'b0});
    firstHsCyc = -1; firstOutCyc = -1;
    for (int n = 0; n < 16; n++) applyStimulus(4'b0001, {{(CH_NUM-1)*DW{1'b0}}, DW'(n)});
    applyStimulus('0, '0);
    stopCapture();
    waitIdle(40, "t2");
    checkOutput("t2_latency", firstOutCyc - firstHsCyc, 2);
    checkOutput("t2_pending", expQ.size(), 0);
    checkOutput("t2_ovf", {28'd0, overflow}, 0);

    // 3: burst of 3 on ch0/ch2 at ratio 2 -> 6 words, last on the 6th
    doReset();
    for (int k = 0; k < 3; k++)
      for (int ch = 0; ch < CH_NUM; ch += 2)
        expQ.push_back('{data: DW'(ch * 256 + 2 * k), chan: CW'(ch), last: (k == 2 && ch == 2)});
    lastAccCyc = -1; busyFallCyc = -1;
    startCapture(ACQ_BURST, 4'b0101, 2, 3);
    for (int n = 0; n < 10; n++) applyStimulus(4'hF, allCh(256, n));
    applyStimulus('0, '0);
    waitIdle(30, "t3");
    checkOutput("t3_words", acceptCount, 6);
    checkOutput("t3_pending", expQ.size(), 0);
    checkOutput("t3_busy_fall", busyFallCyc - lastAccCyc, 1);
    checkOutput("t3_ovf", {28'd0, overflow}, 0);

    // 4: output stalled 10 cycles -> held stable, ch0 overflows, ovfClr clears it
    doReset();
    pk_doutReady = 0;
    expQ.push_back('{data: 16'h0100, chan: '0, last: 1'b0});
    expQ.push_back('{data: 16'h0101, chan: '0, last: 1'b0});
    startCapture(ACQ_CONT, 4'b0001, 1, 0);
    for (int n = 0; n < 4; n++) applyStimulus(4'b0001, {{(CH_NUM-1)*DW{1'b0}}, DW'(16'h0100 + n)});
    for (int n = 0; n < 6; n++) applyStimulus('0, '0);
    checkOutput("t4_ovf_set", {28'd0, overflow}, 32'h1);
    checkOutput("t4_held", {16'd0, pk_dout}, 32'h0100);
    pk_doutReady = 1;
    stopCapture();
    waitIdle(30, "t4");
    checkOutput("t4_pending", expQ.size(), 0);
    checkOutput("t4_ovf_sticky", {28'd0, overflow}, 32'h1);
    ovfClr = 1;
    @(posedge clk); #1;
    ovfClr = 0;
    checkOutput("t4_ovf_clr", {28'd0, overflow}, 0);

    // 5: sysEn dropped with two hold regs full -> flushed, only the output word completes
    doReset();
    pk_doutReady = 0;
    expQ.push_back('{data: 16'h0500, chan: '0, last: 1'b0});
    startCapture(ACQ_CONT, 4'b0011, 1, 0);
    applyStimulus(4'b0011, {32'd0, 16'h0510, 16'h0500});
    applyStimulus(4'b0001, {48'd0, 16'h0501});
    sysEn = 0;
    applyStimulus('0, '0);
    sysEn = 1;
    checkOutput("t5_busy", {31'd0, busy}, 0);
    checkOutput("t5_ready", {28'd0, ad_dinReady}, 0);
    checkOutput("t5_out_valid", {31'd0, pk_doutValid}, 1);
    pk_doutReady = 1;
    for (int n = 0; n < 6; n++) applyStimulus('0, '0);
    checkOutput("t5_words", acceptCount, 1);
    checkOutput("t5_pending", expQ.size(), 0);

    // 6: async reset mid-burst, then a clean burst of 2
    doReset();
    pk_doutReady = 0;
    startCapture(ACQ_BURST, 4'b0001, 1, 4);
    applyStimulus(4'b0001, {48'd0, 16'h0600});
    applyStimulus(4'b0001, {48'd0, 16'h0601});
    checkOutput("t6_pre_valid", {31'd0, pk_doutValid}, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_rst_valid", {31'd0, pk_doutValid}, 0);
    checkOutput("t6_rst_busy", {31'd0, busy}, 0);
    checkOutput("t6_rst_ready", {28'd0, ad_dinReady}, 0);
    checkOutput("t6_rst_dout", {16'd0, pk_dout}, 0);
    ad_dinValid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    acceptCount = 0;
    pk_doutReady = 1;
    expQ.push_back('{data: 16'h0610, chan: '0, last: 1'b0});
    expQ.push_back('{data: 16'h0611, chan: '0, last: 1'b1});
    startCapture(ACQ_BURST, 4'b0001, 1, 2);
    applyStimulus(4'b0001, {48'd0, 16'h0610});
    applyStimulus(4'b0001, {48'd0, 16'h0611});
    applyStimulus('0, '0);
    waitIdle(30, "t6");
    checkOutput("t6_words", acceptCount, 2);
    checkOutput("t6_pending", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
